// File: rtl/dram_bank_cmd_ctrl_if.sv
// Request/command bundle shared by the request front end, the multi-bank
// command sequencer and the PHY command encoder.
interface dram_bank_cmd_ctrl_if #(
    parameter int BANK_W = 2,
    parameter int ROW_W  = 15
);
    logic              init_done;
    logic              dREN;
    logic              dWEN;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic              init_req;
    logic              ram_wait;
    logic [1:0]        row_stat;
    logic [2:0]        cmd;
    logic [BANK_W-1:0] cmd_bank;
    logic [ROW_W-1:0]  cmd_row;
    logic              rf_miss;

    modport master (
        output init_done, dREN, dWEN, bank, row,
        input  init_req, ram_wait, row_stat, cmd, cmd_bank, cmd_row, rf_miss
    );

    modport slave (
        input  init_done, dREN, dWEN, bank, row,
        output init_req, ram_wait, row_stat, cmd, cmd_bank, cmd_row, rf_miss
    );
endinterface

// File: rtl/dram_bank_cmd_ctrl.sv
// Multi-bank DRAM command sequencer: tracks the open row per bank, issues the
// minimal ACT/PRE/RD/WR sequence per request and schedules periodic refresh.
module dram_bank_cmd_ctrl #(
    parameter int NUM_BANKS = 4,
    parameter int ROW_W     = 15,
    parameter int T_RCD     = 4,
    parameter int T_RP      = 4,
    parameter int T_RD      = 6,
    parameter int T_WR      = 6,
    parameter int T_RFC     = 16,
    parameter int T_REFI    = 1560
) (
    input  logic                 CLK,
    input  logic                 nRST,
    dram_bank_cmd_ctrl_if.slave  bus
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int T_M0   = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int T_M1   = (T_RD > T_WR) ? T_RD : T_WR;
    localparam int T_M2   = (T_M0 > T_M1) ? T_M0 : T_M1;
    localparam int T_MAX  = (T_M2 > T_RFC) ? T_M2 : T_RFC;
    localparam int TMR_W  = $clog2(T_MAX + 1);
    localparam int REFI_W = $clog2(T_REFI);

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_ACT  = 3'd1;
    localparam logic [2:0] CMD_RD   = 3'd2;
    localparam logic [2:0] CMD_WR   = 3'd3;
    localparam logic [2:0] CMD_PRE  = 3'd4;
    localparam logic [2:0] CMD_PREA = 3'd5;
    localparam logic [2:0] CMD_REF  = 3'd6;

    localparam logic [1:0] ST_EMPTY    = 2'b00;
    localparam logic [1:0] ST_HIT      = 2'b01;
    localparam logic [1:0] ST_CONFLICT = 2'b10;

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_ACT, S_ACT_W, S_PRE, S_PRE_W,
        S_RW, S_RW_W, S_PREA, S_PREA_W, S_REF, S_REF_W
    } state_t;

    state_t                          state_r;
    logic [TMR_W-1:0]                timer_r;
    logic [NUM_BANKS-1:0]            open_r;
    logic [NUM_BANKS-1:0][ROW_W-1:0] open_row_r;
    logic                            op_wr_r;
    logic [BANK_W-1:0]               req_bank_r;
    logic [ROW_W-1:0]                req_row_r;
    logic [1:0]                      row_stat_r;
    logic [2:0]                      cmd_r;
    logic [BANK_W-1:0]               cmd_bank_r;
    logic [ROW_W-1:0]                cmd_row_r;
    logic [REFI_W-1:0]               refi_cnt_r;
    logic                            rf_pend_r;
    logic                            rf_miss_r;

    logic       req_s;
    logic       done_s;
    logic       any_open_s;
    logic       refi_wrap_s;
    logic       rf_clr_s;
    logic [1:0] class_s;

    assign req_s       = bus.dREN | bus.dWEN;
    assign done_s      = (state_r == S_RW_W) && (timer_r == '0);
    assign any_open_s  = |open_r;
    assign refi_wrap_s = (refi_cnt_r == REFI_W'(T_REFI - 1));
    assign rf_clr_s    = (state_r == S_REF_W) && (timer_r == '0);

    assign bus.init_req = (state_r == S_INIT);
    assign bus.ram_wait = req_s & ~done_s;
    assign bus.row_stat = row_stat_r;
    assign bus.cmd      = cmd_r;
    assign bus.cmd_bank = cmd_bank_r;
    assign bus.cmd_row  = cmd_row_r;
    assign bus.rf_miss  = rf_miss_r;

    // Classify the presented request against the open-row table.
    always_comb begin
        class_s = ST_EMPTY;
        if (open_r[bus.bank]) begin
            if (open_row_r[bus.bank] == bus.row) begin
                class_s = ST_HIT;
            end else begin
                class_s = ST_CONFLICT;
            end
        end else begin
            class_s = ST_EMPTY;
        end
    end

    // Command sequencer; cmd is registered on entry so it appears during the issue state.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r    <= S_INIT;
            timer_r    <= '0;
            open_r     <= '0;
            open_row_r <= '0;
            op_wr_r    <= 1'b0;
            req_bank_r <= '0;
            req_row_r  <= '0;
            row_stat_r <= ST_EMPTY;
            cmd_r      <= CMD_NOP;
            cmd_bank_r <= '0;
            cmd_row_r  <= '0;
        end else begin
            cmd_r      <= CMD_NOP;
            cmd_bank_r <= '0;
            cmd_row_r  <= '0;
            case (state_r)
                S_INIT: begin
                    if (bus.init_done) state_r <= S_IDLE;
                    else               state_r <= S_INIT;
                end
                S_IDLE: begin
                    if (rf_pend_r) begin
                        if (any_open_s) begin
                            state_r <= S_PREA;
                            cmd_r   <= CMD_PREA;
                        end else begin
                            state_r <= S_REF;
                            cmd_r   <= CMD_REF;
                        end
                    end else if (req_s) begin
                        op_wr_r    <= ~bus.dREN;
                        req_bank_r <= bus.bank;
                        req_row_r  <= bus.row;
                        row_stat_r <= class_s;
                        cmd_bank_r <= bus.bank;
                        case (class_s)
                            ST_HIT: begin
                                state_r <= S_RW;
                                cmd_r   <= bus.dREN ? CMD_RD : CMD_WR;
                            end
                            ST_CONFLICT: begin
                                state_r <= S_PRE;
                                cmd_r   <= CMD_PRE;
                            end
                            default: begin
                                state_r   <= S_ACT;
                                cmd_r     <= CMD_ACT;
                                cmd_row_r <= bus.row;
                            end
                        endcase
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ACT: begin
                    open_r[req_bank_r]     <= 1'b1;
                    open_row_r[req_bank_r] <= req_row_r;
                    state_r                <= S_ACT_W;
                    timer_r                <= TMR_W'(T_RCD - 1);
                end
                S_ACT_W: begin
                    if (timer_r == '0) begin
                        state_r    <= S_RW;
                        cmd_r      <= op_wr_r ? CMD_WR : CMD_RD;
                        cmd_bank_r <= req_bank_r;
                    end else begin
                        timer_r <= timer_r - TMR_W'(1);
                    end
                end
                S_PRE: begin
                    open_r[req_bank_r] <= 1'b0;
                    state_r            <= S_PRE_W;
                    timer_r            <= TMR_W'(T_RP - 1);
                end
                S_PRE_W: begin
                    if (timer_r == '0) begin
                        state_r    <= S_ACT;
                        cmd_r      <= CMD_ACT;
                        cmd_bank_r <= req_bank_r;
                        cmd_row_r  <= req_row_r;
                    end else begin
                        timer_r <= timer_r - TMR_W'(1);
                    end
                end
                S_RW: begin
                    state_r <= S_RW_W;
                    timer_r <= op_wr_r ? TMR_W'(T_WR - 1) : TMR_W'(T_RD - 1);
                end
                S_RW_W: begin
                    if (timer_r == '0) state_r <= S_IDLE;
                    else               timer_r <= timer_r - TMR_W'(1);
                end
                S_PREA: begin
                    open_r  <= '0;
                    state_r <= S_PREA_W;
                    timer_r <= TMR_W'(T_RP - 1);
                end
                S_PREA_W: begin
                    if (timer_r == '0) begin
                        state_r <= S_REF;
                        cmd_r   <= CMD_REF;
                    end else begin
                        timer_r <= timer_r - TMR_W'(1);
                    end
                end
                S_REF: begin
                    state_r <= S_REF_W;
                    timer_r <= TMR_W'(T_RFC - 1);
                end
                S_REF_W: begin
                    if (timer_r == '0) state_r <= S_IDLE;
                    else               timer_r <= timer_r - TMR_W'(1);
                end
                default: begin
                    state_r <= S_INIT;
                end
            endcase
        end
    end

    // Refresh interval counter; a wrap that finds a refresh still owed is a miss.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            refi_cnt_r <= '0;
            rf_pend_r  <= 1'b0;
            rf_miss_r  <= 1'b0;
        end else if (state_r == S_INIT) begin
            refi_cnt_r <= '0;
        end else if (refi_wrap_s) begin
            refi_cnt_r <= '0;
            rf_pend_r  <= 1'b1;
            rf_miss_r  <= rf_miss_r | (rf_pend_r & ~rf_clr_s);
        end else begin
            refi_cnt_r <= refi_cnt_r + REFI_W'(1);
            rf_pend_r  <= rf_pend_r & ~rf_clr_s;
        end
    end
endmodule
